// File: rtl/pwm_duty_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_decoder
// Brief    : Measures high time and period of a PWM input, reports duty in
//            percent and flags a line stuck at 0 % or 100 %.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty_pct,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam int               c_DIV_W   = CNT_W + 7;
  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
  localparam logic [c_DIV_W-1:0] c_HUNDRED = c_DIV_W'(100);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  logic               r_sync;
  logic               r_lvl;
  logic               r_lvl_d;
  logic               w_rise;
  logic               w_fall;
  logic               w_edge;
  logic [CNT_W-1:0]   r_run;
  logic               w_timeout;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_h;
  logic [CNT_W-1:0]   r_l;
  logic [CNT_W-1:0]   w_h_nx;
  logic [CNT_W-1:0]   w_l_nx;
  logic               w_capture;

  logic               r_busy;
  logic [2:0]         r_k;
  logic [c_DIV_W-1:0] r_rem;
  logic [CNT_W-1:0]   r_div;
  logic [CNT_W-1:0]   r_cap_h;
  logic [6:0]         r_quo;
  logic [c_DIV_W-1:0] w_trial;
  logic               w_ge;
  logic [6:0]         w_quo_nx;
  logic               w_div_done;

  logic               r_pend;
  logic               w_report_req;
  logic               w_fire;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 1'b0;
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
    end else begin
      r_sync  <= pwm_in;
      r_lvl   <= r_sync;
      r_lvl_d <= r_lvl;
    end
  end

  assign w_rise = r_lvl & ~r_lvl_d;
  assign w_fall = ~r_lvl & r_lvl_d;
  assign w_edge = r_lvl ^ r_lvl_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= '0;
    end else if (w_edge) begin
      r_run <= '0;
    end else if (r_run != c_TIMEOUT) begin
      r_run <= r_run + c_ONE;
    end
  end

  assign w_timeout = (r_run == c_TIMEOUT) && !w_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_l     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_h     <= w_h_nx;
      r_l     <= w_l_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_h_nx     = r_h;
    w_l_nx     = r_l;
    w_capture  = 1'b0;
    if (w_timeout) begin
      w_state_nx = S_IDLE;
      w_h_nx     = '0;
      w_l_nx     = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_state_nx = S_HIGH;
            w_h_nx     = c_ONE;
            w_l_nx     = '0;
          end
        end
        S_HIGH: begin
          if (w_fall) begin
            w_state_nx = S_LOW;
            w_l_nx     = c_ONE;
          end else begin
            w_h_nx = r_h + c_ONE;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            w_capture  = 1'b1;
            w_state_nx = S_HIGH;
            w_h_nx     = c_ONE;
            w_l_nx     = '0;
          end else begin
            w_l_nx = r_l + c_ONE;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_h_nx     = '0;
          w_l_nx     = '0;
        end
      endcase
    end
  end

  // Restoring divider: quotient bit k set when (period << k) fits the remainder
  assign w_trial    = {7'b0, r_div} << r_k;
  assign w_ge       = (w_trial <= r_rem);
  assign w_quo_nx   = r_quo | (7'(w_ge) << r_k);
  assign w_div_done = r_busy && (r_k == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_k     <= 3'd0;
      r_rem   <= '0;
      r_div   <= '0;
      r_cap_h <= '0;
      r_quo   <= '0;
    end else if (w_capture && !r_busy) begin
      r_busy  <= 1'b1;
      r_k     <= 3'd6;
      r_rem   <= {7'b0, r_h} * c_HUNDRED;
      r_div   <= r_h + r_l;
      r_cap_h <= r_h;
      r_quo   <= '0;
    end else if (r_busy) begin
      if (w_ge) begin
        r_rem <= r_rem - w_trial;
      end
      r_quo <= w_quo_nx;
      if (r_k == 3'd0) begin
        r_busy <= 1'b0;
      end else begin
        r_k <= r_k - 3'd1;
      end
    end
  end

  // A new stuck report is due on timeout unless the same condition was
  // already reported; it waits while a division is in flight.
  assign w_report_req = w_timeout && !r_pend && (!stuck || (stuck_level != r_lvl));
  assign w_fire       = (w_report_req || r_pend) && !r_busy && !w_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= 1'b0;
    end else if (w_edge || w_fire) begin
      r_pend <= 1'b0;
    end else if (w_report_req && r_busy) begin
      r_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      high_cnt    <= '0;
      period_cnt  <= '0;
      duty_pct    <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (w_div_done) begin
        high_cnt   <= r_cap_h;
        period_cnt <= r_div;
        duty_pct   <= w_quo_nx;
        meas_valid <= 1'b1;
      end else if (w_fire) begin
        high_cnt    <= '0;
        period_cnt  <= '0;
        duty_pct    <= r_lvl ? 7'd100 : 7'd0;
        meas_valid  <= 1'b1;
        stuck       <= 1'b1;
        stuck_level <= r_lvl;
      end
      if (w_rise) begin
        stuck <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_duty_decoder
// Brief    : Directed stimulus with a scoreboard of expected measurement reports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_decoder;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 40;

  logic             clk;
  logic             rst;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [6:0]       duty_pct;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  typedef struct {
    int h;
    int p;
    int d;
    int st;
    int sl;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  pwm_duty_decoder #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .duty_pct    (duty_pct),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int h, input int p, input int d, input int st,
                      input int sl, input int at);
    exp_t e;
    e.h = h; e.p = p; e.d = d; e.st = st; e.sl = sl; e.cyc = at;
    sb.push_back(e);
  endtask

  // One PWM period starting with a rise; optionally expects the report for
  // the period that this rise completes.
  task automatic pulse(input int hi, input int lo, input bit exp_prev,
                       input int eh, input int ep, input int ed);
    if (exp_prev) push(eh, ep, ed, 0, 0, cyc + 10);
    pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic end_test(input string name);
    repeat (14) @(negedge clk);
    chk({name, "_sb_drained"}, sb.size(), 0);
    sb.delete();
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every meas_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (meas_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_meas: got pulse duty=%0d period=%0d expected none (cycle %0d)",
                 duty_pct, period_cnt, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mv_cycle",  cyc,        e.cyc);
        chk("mv_high",   high_cnt,   e.h);
        chk("mv_period", period_cnt, e.p);
        chk("mv_duty",   duty_pct,   e.d);
        chk("mv_stuck",  stuck,      e.st);
        if (e.st == 1) chk("mv_stuck_level", stuck_level, e.sl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_high_cnt",    high_cnt,    0);
    chk("rst_period_cnt",  period_cnt,  0);
    chk("rst_duty",        duty_pct,    0);
    chk("rst_meas_valid",  meas_valid,  0);
    chk("rst_stuck",       stuck,       0);
    chk("rst_stuck_level", stuck_level, 0);
    rst = 1'b0;

    // Steady 5/10
    pulse(5, 5, 0, 0, 0, 0);
    repeat (3) pulse(5, 5, 1, 5, 10, 50);
    end_test("t1");

    // High time stepped on a 10-cycle period
    pulse(5, 5, 0, 0, 0, 0);
    pulse(1, 9, 1, 5, 10, 50);
    pulse(3, 7, 1, 1, 10, 10);
    pulse(9, 1, 1, 3, 10, 30);
    pulse(5, 5, 1, 9, 10, 90);
    end_test("t2");

    // Held low from reset release
    n0 = cyc;
    push(0, 0, 0, 1, 0, n0 + TIMEOUT + 1);
    repeat (TIMEOUT) @(negedge clk);
    chk("t3_stuck_early", stuck, 0);
    @(negedge clk);
    chk("t3_stuck_set", stuck, 1);
    chk("t3_stuck_lvl", stuck_level, 0);
    repeat (5) @(negedge clk);
    pulse(3, 3, 0, 0, 0, 0);
    chk("t3_stuck_clear", stuck, 0);
    end_test("t3");

    // Steady then held high, then resume 7/10
    pulse(5, 5, 0, 0, 0, 0);
    pulse(5, 5, 1, 5, 10, 50);
    push(5, 10, 50, 0, 0, cyc + 10);
    push(0, 0, 100, 1, 1, cyc + TIMEOUT + 4);
    pwm_in = 1'b1;
    repeat (TIMEOUT + 10) @(negedge clk);
    chk("t4_stuck_set", stuck, 1);
    chk("t4_stuck_lvl", stuck_level, 1);
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_stuck_hold_fall", stuck, 1);
    pulse(7, 3, 0, 0, 0, 0);
    chk("t4_stuck_clear", stuck, 0);
    pulse(7, 3, 1, 7, 10, 70);
    pulse(7, 3, 1, 7, 10, 70);
    end_test("t4");

    // 3-cycle period: only every third capture finds the divider idle
    for (int i = 0; i < 10; i++) begin
      pulse(1, 2, (i % 3) == 1, 1, 3, 33);
    end
    end_test("t5");

    // Minimum period of 2
    pulse(1, 1, 0, 0, 0, 0);
    pulse(1, 1, 1, 1, 2, 50);
    end_test("t6");

    // Reset three cycles after a capture aborts the division
    pulse(5, 5, 0, 0, 0, 0);
    pwm_in = 1'b1;
    repeat (6) @(negedge clk);
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t7_high_cnt",   high_cnt,   0);
    chk("t7_period_cnt", period_cnt, 0);
    chk("t7_duty",       duty_pct,   0);
    chk("t7_stuck",      stuck,      0);
    pulse(4, 6, 0, 0, 0, 0);
    pulse(4, 6, 1, 4, 10, 40);
    end_test("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
